// File: rtl/video_clk_pkg.sv
// Shared types and constants for the multi-channel NCO clock-enable generator.
// Increment constants assume a 50 MHz reference clock.
package video_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE
  } fsm_state_e;

  localparam int DEF_ACC_W = 32;

  localparam logic [DEF_ACC_W-1:0] INC_25M  = 32'h8000_0000;
  localparam logic [DEF_ACC_W-1:0] INC_33M3 = 32'hAAAA_AAAB;
  localparam logic [DEF_ACC_W-1:0] INC_12M5 = 32'h4000_0000;

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator with loadable increment/phase, producing a
// one-cycle strobe on each accumulator wrap and a registered MSB square enable.
module nco_channel #(
  parameter int               ACC_W     = 32,
  parameter logic [ACC_W-1:0] INC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             ce,
  output logic             clk_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             ce_q, ce_d;
  logic             clk_q, clk_d;
  logic [ACC_W:0]   sum;

  // A load overrides advancing and suppresses the strobe for that cycle.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d = acc_q;
    inc_d = inc_q;
    ce_d  = 1'b0;
    clk_d = clk_q;
    if (load) begin
      inc_d = load_inc;
      acc_d = load_phase;
      clk_d = load_phase[ACC_W-1];
    end else if (enable) begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = sum[ACC_W];
      clk_d = sum[ACC_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      inc_q <= INC_RESET;
      ce_q  <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
      ce_q  <= ce_d;
      clk_q <= clk_d;
    end
  end

  assign ce    = ce_q;
  assign clk_o = clk_q;

endmodule

// File: rtl/video_nco_clkgen.sv
// Multi-channel fractional clock-enable generator: per-channel NCOs plus a retune
// FSM that applies one channel update at a time and reports lock after settling.
module video_nco_clkgen
  import video_clk_pkg::*;
#(
  parameter int                      N_CH        = 3,
  parameter int                      ACC_W       = DEF_ACC_W,
  parameter int                      LOCK_CYCLES = 16,
  parameter logic [N_CH*ACC_W-1:0]   INC_INIT    = {INC_12M5, INC_33M3, INC_25M},
  localparam int                     CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [ACC_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic [N_CH-1:0]  ce_out,
  output logic [N_CH-1:0]  clk_out,
  output logic             locked
);

  localparam int                CNT_W  = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LD = CNT_W'(LOCK_CYCLES);
  localparam logic [CH_W:0]     N_CH_L = (CH_W + 1)'(N_CH);

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_int_n;
  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CH_W-1:0]  cap_ch_q, cap_ch_d;
  logic [ACC_W-1:0] cap_inc_q, cap_inc_d;
  logic [ACC_W-1:0] cap_phase_q, cap_phase_d;

  // Reset asserts asynchronously everywhere but releases two edges later.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    cap_ch_d    = cap_ch_q;
    cap_inc_d   = cap_inc_q;
    cap_phase_d = cap_phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          cap_ch_d    = cfg_ch;
          cap_inc_d   = cfg_inc;
          cap_phase_d = cfg_phase;
          if ({1'b0, cfg_ch} >= N_CH_L) err_d   = 1'b1;
          else                          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        locked_d = 1'b0;
        cnt_d    = CNT_LD;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          locked_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= CNT_LD;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      cap_ch_q    <= '0;
      cap_inc_q   <= '0;
      cap_phase_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      cap_ch_q    <= cap_ch_d;
      cap_inc_q   <= cap_inc_d;
      cap_phase_q <= cap_phase_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign cfg_err   = err_q;
  assign locked    = locked_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic load;
    assign load = (state_q == ST_APPLY) && (cap_ch_q == CH_W'(i));

    nco_channel #(
      .ACC_W    (ACC_W),
      .INC_RESET(INC_INIT[i*ACC_W +: ACC_W])
    ) u_nco (
      .clk       (refclk),
      .rst_n     (rst_int_n),
      .enable    (enable),
      .load      (load),
      .load_inc  (cap_inc_q),
      .load_phase(cap_phase_q),
      .ce        (ce_out[i]),
      .clk_o     (clk_out[i])
    );
  end

endmodule

// File: tb/tb_video_nco_clkgen.sv
// Directed self-checking bench for video_nco_clkgen: reset/lock timing, default
// rates, retune, bad-channel error, freeze, and reset during settle.
module tb_video_nco_clkgen;

  localparam int N_CH  = 3;
  localparam int ACC_W = 32;
  localparam int CH_W  = 2;

  logic             refclk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;
  logic             cfg_err;
  logic [N_CH-1:0]  ce_out;
  logic [N_CH-1:0]  clk_out;
  logic             locked;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 refclk = ~refclk;

  video_nco_clkgen dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .ce_out   (ce_out),
    .clk_out  (clk_out),
    .locked   (locked)
  );

  // One rising edge, then sample/drive on the following falling edge.
  task automatic cycle();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic run_count(input int n, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (n) begin
      cycle();
      c0 += int'(ce_out[0]);
      c1 += int'(ce_out[1]);
      c2 += int'(ce_out[2]);
    end
  endtask

  // Release lands mid-cycle: 2 sync edges, then SETTLE counts 16..0 over 17 edges,
  // so locked must be low through posedge 18 and high after posedge 19.
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
    repeat (5) cycle();
    n_cmp++; if (ce_out !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_ce got %b want 000", ce_out); end
    n_cmp++; if (clk_out !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_clk got %b want 000", clk_out); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready got %b want 0", cfg_ready); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err got %b want 0", cfg_err); end
    rst_n = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      cycle();
      if (k <= 18) begin
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_early k=%0d got %b want 0", k, locked); end
      end
      if (k == 18) begin
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL ready_early got %b want 0", cfg_ready); end
      end
      if (k == 19) begin
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("[TB] FAIL lock_on_time got %b want 1", locked); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL ready_on_time got %b want 1", cfg_ready); end
      end
    end
  endtask

  // ch0 inc 1/2, ch1 inc ~2/3, ch2 inc 1/4 of full scale.
  task automatic test_default_rates();
    int c0, c1, c2;
    run_count(300, c0, c1, c2);
    n_cmp++; if (c0 !== 150) begin n_bad++; $display("[TB] FAIL rate_ch0 got %0d want 150", c0); end
    n_cmp++; if (c1 < 199 || c1 > 201) begin n_bad++; $display("[TB] FAIL rate_ch1 got %0d want 200+/-1", c1); end
    n_cmp++; if (c2 !== 75) begin n_bad++; $display("[TB] FAIL rate_ch2 got %0d want 75", c2); end
  endtask

  // Accept at T; APPLY at T+1 loads acc=0; wraps at T+3, T+5, ..., T+17 -> 8 strobes.
  task automatic test_retune();
    int c0, c1, c2;
    c0 = 0; c1 = 0; c2 = 0;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL retune_ready_pre got %b want 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 32'h8000_0000; cfg_phase = 32'h0;
    cycle();
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL retune_ready_drop got %b want 0", cfg_ready); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("[TB] FAIL retune_lock_T got %b want 1", locked); end
    for (int k = 1; k <= 18; k++) begin
      cycle();
      c0 += int'(ce_out[0]);
      c1 += int'(ce_out[1]);
      c2 += int'(ce_out[2]);
      if (k <= 17) begin
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL retune_lock_low k=%0d got %b want 0", k, locked); end
      end
      if (k == 1 || k == 2) begin
        n_cmp++; if (ce_out[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL retune_ce2_quiet k=%0d got %b want 0", k, ce_out[2]); end
      end
      if (k == 3) begin
        n_cmp++; if (ce_out[2] !== 1'b1) begin n_bad++; $display("[TB] FAIL retune_ce2_first got %b want 1", ce_out[2]); end
      end
    end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("[TB] FAIL retune_relock got %b want 1", locked); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL retune_ready_back got %b want 1", cfg_ready); end
    n_cmp++; if (c0 !== 9) begin n_bad++; $display("[TB] FAIL retune_ch0_count got %0d want 9", c0); end
    n_cmp++; if (c1 !== 12) begin n_bad++; $display("[TB] FAIL retune_ch1_count got %0d want 12", c1); end
    n_cmp++; if (c2 !== 8) begin n_bad++; $display("[TB] FAIL retune_ch2_count got %0d want 8", c2); end
  endtask

  task automatic test_cfg_err();
    int c0, c1, c2;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 32'h0; cfg_phase = 32'hFFFF_FFFF;
    cycle();
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("[TB] FAIL err_pulse got %b want 1", cfg_err); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("[TB] FAIL err_locked got %b want 1", locked); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL err_ready got %b want 1", cfg_ready); end
    cycle();
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("[TB] FAIL err_one_cycle got %b want 0", cfg_err); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("[TB] FAIL err_locked_after got %b want 1", locked); end
    run_count(12, c0, c1, c2);
    n_cmp++; if (c0 !== 6) begin n_bad++; $display("[TB] FAIL err_ch0_count got %0d want 6", c0); end
    n_cmp++; if (c1 !== 8) begin n_bad++; $display("[TB] FAIL err_ch1_count got %0d want 8", c1); end
    n_cmp++; if (c2 !== 6) begin n_bad++; $display("[TB] FAIL err_ch2_count got %0d want 6", c2); end
  endtask

  // ch0 and ch2 both step by half scale, so clk_out toggles and a strobe
  // follows whenever the held MSB was 1.
  task automatic test_enable();
    logic [N_CH-1:0] held;
    int c0, c1, c2;
    held = clk_out;
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      n_cmp++;
      if ({ce_out, clk_out} !== {3'b000, held}) begin
        n_bad++; $display("[TB] FAIL freeze k=%0d got ce=%b clk=%b want ce=000 clk=%b", k, ce_out, clk_out, held);
      end
    end
    enable = 1'b1;
    cycle();
    n_cmp++; if (clk_out[0] !== ~held[0]) begin n_bad++; $display("[TB] FAIL resume_clk0 got %b want %b", clk_out[0], ~held[0]); end
    n_cmp++; if (ce_out[0] !== held[0]) begin n_bad++; $display("[TB] FAIL resume_ce0 got %b want %b", ce_out[0], held[0]); end
    n_cmp++; if (clk_out[2] !== ~held[2]) begin n_bad++; $display("[TB] FAIL resume_clk2 got %b want %b", clk_out[2], ~held[2]); end
    run_count(30, c0, c1, c2);
    n_cmp++; if (c0 !== 15) begin n_bad++; $display("[TB] FAIL resume_ch0_count got %0d want 15", c0); end
    n_cmp++; if (c1 !== 20) begin n_bad++; $display("[TB] FAIL resume_ch1_count got %0d want 20", c1); end
    n_cmp++; if (c2 !== 15) begin n_bad++; $display("[TB] FAIL resume_ch2_count got %0d want 15", c2); end
  endtask

  task automatic test_reset_mid_settle();
    int c0, c1, c2;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 32'h1000_0000; cfg_phase = 32'h1234_5678;
    cycle();
    cfg_valid = 1'b0;
    repeat (5) cycle();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_settle_locked got %b want 0", locked); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ce_out, clk_out, locked, cfg_ready, cfg_err} !== 9'b0) begin
      n_bad++; $display("[TB] FAIL async_reset got ce=%b clk=%b lk=%b rdy=%b err=%b want all 0",
                        ce_out, clk_out, locked, cfg_ready, cfg_err);
    end
    @(negedge refclk);
    repeat (4) cycle();
    rst_n = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      cycle();
      if (k == 18) begin
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL rerst_lock_early got %b want 0", locked); end
      end
      if (k == 19) begin
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("[TB] FAIL rerst_lock_on_time got %b want 1", locked); end
      end
    end
    run_count(12, c0, c1, c2);
    n_cmp++; if (c0 !== 6) begin n_bad++; $display("[TB] FAIL rerst_ch0_count got %0d want 6", c0); end
    n_cmp++; if (c1 !== 8) begin n_bad++; $display("[TB] FAIL rerst_ch1_count got %0d want 8", c1); end
    n_cmp++; if (c2 !== 3) begin n_bad++; $display("[TB] FAIL rerst_ch2_count got %0d want 3", c2); end
  endtask

  initial begin
    test_reset();
    test_default_rates();
    test_retune();
    test_cfg_err();
    test_enable();
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
